// File: rtl/writeback_queue.sv
// Write-back queue: merges ALU and load results into an in-order FIFO and drains
// one entry per cycle onto the register file's single write port.
module writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] rf_RW,
    output logic [DATA_W-1:0] rf_BusW,
    output logic              rf_sig_enable_write,
    output logic [31:0]       pending_mask,
    output logic              empty,
    output logic              overflow_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] r_rd   [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_rf_rw;
    logic [DATA_W-1:0] r_rf_busw;
    logic              r_rf_we;
    logic              r_overflow;

    logic              w_in_ready;
    logic              w_req_mem;
    logic              w_req_alu;
    logic              w_push_mem;
    logic              w_push_alu;
    logic              w_pop;
    logic [1:0]        w_npush;
    logic [PTR_W-1:0]  w_alu_ptr;
    logic              w_ovf;
    logic [31:0]       w_mask;
    logic [PTR_W-1:0]  w_idx;

    // Two free slots are required so a dual push can never overrun the FIFO.
    assign w_in_ready = (r_count <= CNT_W'(DEPTH - 2));
    assign w_req_mem  = mem_valid && (mem_rd != '0);
    assign w_req_alu  = alu_valid && (alu_rd != '0);
    assign w_push_mem = w_req_mem && w_in_ready;
    assign w_push_alu = w_req_alu && w_in_ready;
    assign w_pop      = (r_count != '0);
    assign w_npush    = {1'b0, w_push_mem} + {1'b0, w_push_alu};
    assign w_alu_ptr  = r_wr_ptr + PTR_W'(w_push_mem);
    assign w_ovf      = (w_req_mem || w_req_alu) && !w_in_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rf_rw    <= '0;
            r_rf_busw  <= '0;
            r_rf_we    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            // Load result takes the older slot so an ALU write to the same rd wins.
            if (w_push_mem) begin
                r_rd[r_wr_ptr]   <= mem_rd;
                r_data[r_wr_ptr] <= mem_data;
            end
            if (w_push_alu) begin
                r_rd[w_alu_ptr]   <= alu_rd;
                r_data[w_alu_ptr] <= alu_data;
            end
            if (w_pop) begin
                r_rf_rw   <= r_rd[r_rd_ptr];
                r_rf_busw <= r_data[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
            end
            r_rf_we  <= w_pop;
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_npush);
            r_count  <= r_count + CNT_W'(w_npush) - CNT_W'(w_pop);
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        w_mask = '0;
        w_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr + PTR_W'(i);
            if (CNT_W'(i) < r_count) begin
                w_mask[r_rd[w_idx]] = 1'b1;
            end
        end
        if (r_rf_we) begin
            w_mask[r_rf_rw] = 1'b1;
        end
        w_mask[0] = 1'b0;
    end

    assign in_ready            = w_in_ready;
    assign rf_RW               = r_rf_rw;
    assign rf_BusW             = r_rf_busw;
    assign rf_sig_enable_write = r_rf_we;
    assign pending_mask        = w_mask;
    assign empty               = (r_count == '0);
    assign overflow_err        = r_overflow;

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: scenario tasks with inline checks plus
// a scoreboard that tracks every accepted write through to the register file port.
module tb_writeback_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              alu_valid = 1'b0;
    logic [ADDR_W-1:0] alu_rd = '0;
    logic [DATA_W-1:0] alu_data = '0;
    logic              mem_valid = 1'b0;
    logic [ADDR_W-1:0] mem_rd = '0;
    logic [DATA_W-1:0] mem_data = '0;
    logic              in_ready;
    logic [ADDR_W-1:0] rf_RW;
    logic [DATA_W-1:0] rf_BusW;
    logic              rf_sig_enable_write;
    logic [31:0]       pending_mask;
    logic              empty;
    logic              overflow_err;

    writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
        .in_ready(in_ready), .rf_RW(rf_RW), .rf_BusW(rf_BusW),
        .rf_sig_enable_write(rf_sig_enable_write), .pending_mask(pending_mask),
        .empty(empty), .overflow_err(overflow_err)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;

    // Reference model state: queue of expected writes, occupancy, expected output enable.
    logic [ADDR_W+DATA_W-1:0] sb[$];
    int   m_cnt    = 0;
    logic m_out_en = 1'b0;
    logic m_ovf    = 1'b0;

    always @(posedge clock) begin
        if (reset_n) begin
            int   np;
            logic ready;
            np    = 0;
            ready = (m_cnt <= DEPTH - 2);
            if (mem_valid && mem_rd != 0) begin
                if (ready) begin sb.push_back({mem_rd, mem_data}); np++; end
                else m_ovf = 1'b1;
            end
            if (alu_valid && alu_rd != 0) begin
                if (ready) begin sb.push_back({alu_rd, alu_data}); np++; end
                else m_ovf = 1'b1;
            end
            m_out_en = (m_cnt > 0);
            m_cnt    = m_cnt + np - (m_out_en ? 1 : 0);
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            logic [ADDR_W+DATA_W-1:0] exp_e;
            total++;
            if (rf_sig_enable_write !== m_out_en)
                $display("FAIL sb_we: got %b want %b at %0t", rf_sig_enable_write, m_out_en, $time);
            else passed++;
            if (m_out_en) begin
                total++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_underflow: got write rd=%0d with no expected entry", rf_RW);
                end else begin
                    exp_e = sb.pop_front();
                    if ({rf_RW, rf_BusW} !== exp_e)
                        $display("FAIL sb_data: got rd=%0d data=%h want rd=%0d data=%h",
                                 rf_RW, rf_BusW, exp_e[ADDR_W+DATA_W-1:DATA_W], exp_e[DATA_W-1:0]);
                    else passed++;
                end
            end
            total++;
            if (in_ready !== (m_cnt <= DEPTH - 2) || empty !== (m_cnt == 0) || overflow_err !== m_ovf)
                $display("FAIL sb_status: got rdy=%b empty=%b ovf=%b want rdy=%b empty=%b ovf=%b",
                         in_ready, empty, overflow_err, (m_cnt <= DEPTH - 2), (m_cnt == 0), m_ovf);
            else passed++;
        end
    end

    // Called just after a negedge: apply inputs, cross one posedge, return just after the next negedge.
    task automatic step(input logic mv, input logic [ADDR_W-1:0] mrd, input logic [DATA_W-1:0] md,
                        input logic av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] ad);
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        @(negedge clock);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_cnt != 0 || m_out_en) && n < 20) begin idle(); n++; end
        idle();
        total++;
        if (sb.size() != 0 || empty !== 1'b1)
            $display("FAIL drain: got %0d pending entries empty=%b want 0 entries empty=1", sb.size(), empty);
        else passed++;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        sb.delete(); m_cnt = 0; m_out_en = 1'b0; m_ovf = 1'b0;
        idle(); idle();
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        step(1'b0, '0, '0, 1'b1, 5'd5, 32'hDEADBEEF);
        total++;
        if (rf_sig_enable_write !== 1'b0 || pending_mask !== 32'h20)
            $display("FAIL single_e0: got we=%b mask=%h want we=0 mask=00000020", rf_sig_enable_write, pending_mask);
        else passed++;
        idle();
        total++;
        if (rf_sig_enable_write !== 1'b1 || rf_RW !== 5'd5 || rf_BusW !== 32'hDEADBEEF || pending_mask !== 32'h20)
            $display("FAIL single_e1: got we=%b rd=%0d data=%h mask=%h want 1 5 deadbeef 00000020",
                     rf_sig_enable_write, rf_RW, rf_BusW, pending_mask);
        else passed++;
        idle();
        total++;
        if (rf_sig_enable_write !== 1'b0 || pending_mask !== 32'h0 || rf_RW !== 5'd5)
            $display("FAIL single_e2: got we=%b mask=%h rd=%0d want we=0 mask=0 rd=5 held",
                     rf_sig_enable_write, pending_mask, rf_RW);
        else passed++;
        drain();
    endtask

    task automatic test_dual_same_rd();
        step(1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2);
        idle();
        total++;
        if (rf_sig_enable_write !== 1'b1 || rf_RW !== 5'd7 || rf_BusW !== 32'd1 || pending_mask !== 32'h80)
            $display("FAIL dual_first: got we=%b rd=%0d data=%0d mask=%h want 1 7 1 00000080",
                     rf_sig_enable_write, rf_RW, rf_BusW, pending_mask);
        else passed++;
        idle();
        total++;
        if (rf_sig_enable_write !== 1'b1 || rf_RW !== 5'd7 || rf_BusW !== 32'd2)
            $display("FAIL dual_second: got we=%b rd=%0d data=%0d want 1 7 2", rf_sig_enable_write, rf_RW, rf_BusW);
        else passed++;
        drain();
    endtask

    task automatic test_r0_drop();
        step(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234);
        idle();
        total++;
        if (rf_sig_enable_write !== 1'b0 || overflow_err !== 1'b0 || empty !== 1'b1 || pending_mask !== 32'h0)
            $display("FAIL r0_drop: got we=%b ovf=%b empty=%b mask=%h want 0 0 1 0",
                     rf_sig_enable_write, overflow_err, empty, pending_mask);
        else passed++;
        drain();
    endtask

    task automatic test_backpressure();
        step(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2);
        total++;
        if (in_ready !== 1'b1) $display("FAIL bp_ready2: got %b want 1", in_ready);
        else passed++;
        step(1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hA4);
        total++;
        if (in_ready !== 1'b0 || overflow_err !== 1'b0)
            $display("FAIL bp_ready3: got rdy=%b ovf=%b want rdy=0 ovf=0", in_ready, overflow_err);
        else passed++;
        step(1'b1, 5'd5, 32'hA5, 1'b1, 5'd6, 32'hA6);
        total++;
        if (overflow_err !== 1'b1 || pending_mask !== 32'h1C)
            $display("FAIL bp_overflow: got ovf=%b mask=%h want ovf=1 mask=0000001c", overflow_err, pending_mask);
        else passed++;
        drain();
        total++;
        if (overflow_err !== 1'b1) $display("FAIL bp_sticky: got %b want 1", overflow_err);
        else passed++;
    endtask

    task automatic test_wrap();
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, '0, '0, 1'b1, ADDR_W'(i), 32'h100 + DATA_W'(i));
            if (i >= 2) begin
                total++;
                if (rf_sig_enable_write !== 1'b1 || rf_RW !== ADDR_W'(i - 1))
                    $display("FAIL wrap_order: got we=%b rd=%0d want we=1 rd=%0d", rf_sig_enable_write, rf_RW, i - 1);
                else passed++;
            end
        end
        idle();
        total++;
        if (rf_RW !== 5'd10 || rf_BusW !== 32'h10A)
            $display("FAIL wrap_last: got rd=%0d data=%h want rd=10 data=0000010a", rf_RW, rf_BusW);
        else passed++;
        drain();
    endtask

    task automatic test_reset();
        step(1'b1, 5'd8, 32'hB1, 1'b1, 5'd9, 32'hB2);
        step(1'b1, 5'd10, 32'hB3, 1'b1, 5'd11, 32'hB4);
        mem_valid = 1'b0; alu_valid = 1'b0;
        reset_n = 1'b0;
        sb.delete(); m_cnt = 0; m_out_en = 1'b0; m_ovf = 1'b0;
        #1;
        total++;
        if (rf_sig_enable_write !== 1'b0 || rf_RW !== '0 || rf_BusW !== '0 || empty !== 1'b1 ||
            pending_mask !== 32'h0 || in_ready !== 1'b1 || overflow_err !== 1'b0)
            $display("FAIL reset_async: got we=%b rd=%0d data=%h empty=%b mask=%h rdy=%b ovf=%b want 0 0 0 1 0 1 0",
                     rf_sig_enable_write, rf_RW, rf_BusW, empty, pending_mask, in_ready, overflow_err);
        else passed++;
        @(negedge clock);
        idle();
        reset_n = 1'b1;
        idle(); idle();
        total++;
        if (rf_sig_enable_write !== 1'b0 || empty !== 1'b1)
            $display("FAIL reset_discard: got we=%b empty=%b want 0 1", rf_sig_enable_write, empty);
        else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clock);
        apply_reset();
        total++;
        if (empty !== 1'b1 || in_ready !== 1'b1 || rf_sig_enable_write !== 1'b0 || pending_mask !== 32'h0)
            $display("FAIL por: got empty=%b rdy=%b we=%b mask=%h want 1 1 0 0",
                     empty, in_ready, rf_sig_enable_write, pending_mask);
        else passed++;
        test_single();
        test_dual_same_rd();
        test_r0_drop();
        test_backpressure();
        test_wrap();
        test_reset();
        test_single();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
